// File: rtl/mem_resp_dm_cache_pkg.sv
// mem_resp_pkg: shared constants for the mem_resp_dm_cache responder.
//   - FSM state encodings (IDLE/WB/FILL/RESP)
//   - address field offsets and bus widths
//   - helpers deriving the tag width and the latency-counter width
package mem_resp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int WORDS   = 4;   // words per line
    localparam int OFS_LSB = 1;   // word-in-line field
    localparam int IDX_LSB = 3;   // line index field

    function automatic int tag_w(input int index_w);
        return ADDR_W - IDX_LSB - index_w;
    endfunction

    function automatic int lat_w(input int miss_lat, input int wb_lat);
        return $clog2(miss_lat + wb_lat + 1);
    endfunction

endpackage

// File: rtl/mem_resp_dm_cache_line_store.sv
// dm_line_store: tag/valid/dirty/data arrays of the direct-mapped cache.
//   rd_idx            -> rd_tag, rd_valid, rd_dirty, rd_line (combinational read)
//   wr_en, wr_full=1  -> whole-line fill: data=wr_line, tag=wr_tag, valid=1, dirty=0
//   wr_en, wr_full=0  -> single word write at wr_ofs with wr_word, dirty=1
// Only valid and dirty bits are reset; tag and data keep their contents.
module dm_line_store
    import mem_resp_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INDEX_W-1:0]        rd_idx,
    output logic [TAG_W-1:0]          rd_tag,
    output logic                      rd_valid,
    output logic                      rd_dirty,
    output logic [WORDS*DATA_W-1:0]   rd_line,
    input  logic                      wr_en,
    input  logic                      wr_full,
    input  logic [INDEX_W-1:0]        wr_idx,
    input  logic [1:0]                wr_ofs,
    input  logic [DATA_W-1:0]         wr_word,
    input  logic [WORDS*DATA_W-1:0]   wr_line,
    input  logic [TAG_W-1:0]          wr_tag
);

    localparam int LINES = 1 << INDEX_W;

    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [WORDS*DATA_W-1:0] data_q [LINES];
    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        dirty_q;

    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            if (wr_full) begin
                valid_q[wr_idx] <= 1'b1;
                dirty_q[wr_idx] <= 1'b0;
            end else begin
                dirty_q[wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_full) begin
                tag_q[wr_idx]  <= wr_tag;
                data_q[wr_idx] <= wr_line;
            end else begin
                data_q[wr_idx][32'(wr_ofs)*DATA_W +: DATA_W] <= wr_word;
            end
        end
    end

endmodule

// File: rtl/mem_resp_dm_cache.sv
// mem_resp_dm_cache: latency-exact memory responder. Direct-mapped,
// write-back, write-allocate cache over an internal word-wide backing store.
//   clk, rst          clock, asynchronous active-high reset
//   Addr[15:0]        byte address ([2:1] word, [3+:INDEX_W] index, rest tag)
//   DataIn[15:0]      write data
//   Rd, Wr            request strobes, held stable by the initiator while Stall
//   DataOut[15:0]     read data, meaningful when Done && Rd, held otherwise
//   Done              one-cycle completion pulse
//   Stall             high in every WB and FILL cycle
//   CacheHit, Err     qualify Done (hit / illegal request not performed)
module mem_resp_dm_cache
    import mem_resp_pkg::*;
#(
    parameter int INDEX_W  = 5,
    parameter int MISS_LAT = 8,
    parameter int WB_LAT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        Err
);

    localparam int TAG_W      = tag_w(INDEX_W);
    localparam int LAT_W      = lat_w(MISS_LAT, WB_LAT);
    localparam int BACK_WORDS = 1 << (ADDR_W - 1);
    // Counter holds "cycles left minus one": WB spans WB_LAT cycles and FILL
    // spans MISS_LAT-1, so Done lands exactly MISS_LAT (+WB_LAT) after accept.
    localparam logic [LAT_W-1:0] WB_LOAD   = LAT_W'(WB_LAT - 1);
    localparam logic [LAT_W-1:0] FILL_LOAD = LAT_W'(MISS_LAT - 2);

    logic [1:0]              state;
    logic [LAT_W-1:0]        cnt;
    logic [DATA_W-1:0]       backing [BACK_WORDS];

    logic [1:0]              ofs;
    logic [INDEX_W-1:0]      idx;
    logic [TAG_W-1:0]        tag;
    logic [TAG_W-1:0]        st_tag;
    logic                    st_valid, st_dirty;
    logic [WORDS*DATA_W-1:0] st_line, fill_line;
    logic [DATA_W-1:0]       word;
    logic                    illegal, accept, hit, replay, complete;
    logic                    st_we, st_full;

    // The initiator holds the request stable through the miss, so the live
    // address drives every phase; no request register is needed.
    assign ofs     = Addr[OFS_LSB +: 2];
    assign idx     = Addr[IDX_LSB +: INDEX_W];
    assign tag     = Addr[ADDR_W-1 -: TAG_W];
    assign word    = st_line[32'(ofs)*DATA_W +: DATA_W];

    assign Stall    = (state == ST_WB) || (state == ST_FILL);
    assign illegal  = (Rd && Wr) || Addr[0];
    assign accept   = (Rd || Wr) && !Stall;
    assign hit      = st_valid && (st_tag == tag);
    // The last FILL cycle replays the request against the freshly filled line.
    assign replay   = (state == ST_FILL) && (cnt == '0);
    assign complete = replay || (accept && !illegal && hit);

    always_comb begin
        fill_line = '0;
        for (int k = 0; k < WORDS; k++)
            fill_line[k*DATA_W +: DATA_W] = backing[{tag, idx, 2'(k)}];
    end

    // Line fill happens on the first FILL cycle so the replay can read it back.
    always_comb begin
        st_we   = 1'b0;
        st_full = 1'b0;
        if (complete && Wr) begin
            st_we = 1'b1;
        end else if ((state == ST_FILL) && (cnt == FILL_LOAD)) begin
            st_we   = 1'b1;
            st_full = 1'b1;
        end
    end

    dm_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_tag   (st_tag),
        .rd_valid (st_valid),
        .rd_dirty (st_dirty),
        .rd_line  (st_line),
        .wr_en    (st_we),
        .wr_full  (st_full),
        .wr_idx   (idx),
        .wr_ofs   (ofs),
        .wr_word  (DataIn),
        .wr_line  (fill_line),
        .wr_tag   (tag)
    );

    // Victim copy-out on the first WB cycle, to the victim's own address.
    always_ff @(posedge clk) begin
        if ((state == ST_WB) && (cnt == WB_LOAD)) begin
            for (int k = 0; k < WORDS; k++)
                backing[{st_tag, idx, 2'(k)}] <= st_line[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            Done     <= 1'b0;
            CacheHit <= 1'b0;
            Err      <= 1'b0;
            DataOut  <= '0;
        end else begin
            Done     <= 1'b0;
            CacheHit <= 1'b0;
            Err      <= 1'b0;
            case (state)
                ST_WB: begin
                    if (cnt == '0) begin
                        state <= ST_FILL;
                        cnt   <= FILL_LOAD;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                ST_FILL: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                        Done  <= 1'b1;
                        if (Rd) DataOut <= word;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                default: begin
                    // IDLE and RESP both accept; RESP is the Done cycle of a miss.
                    state <= ST_IDLE;
                    if (accept) begin
                        if (illegal) begin
                            Done <= 1'b1;
                            Err  <= 1'b1;
                        end else if (hit) begin
                            Done     <= 1'b1;
                            CacheHit <= 1'b1;
                            if (Rd) DataOut <= word;
                        end else if (st_valid && st_dirty) begin
                            state <= ST_WB;
                            cnt   <= WB_LOAD;
                        end else begin
                            state <= ST_FILL;
                            cnt   <= FILL_LOAD;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_resp_dm_cache.sv
// Directed bench for mem_resp_dm_cache. Stimulus pushes expected responses
// into a queue; a negedge monitor pops and compares on every Done.
module tb_mem_resp_dm_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr = '0, DataIn = '0;
    logic        Rd = 1'b0, Wr = 1'b0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, Err;

    mem_resp_dm_cache dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .Err(Err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic        chk_data;
        logic        hit;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every Done pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && Done) begin
            chk("done_while_stall", Stall, 1'b0);
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got Done=1 expected no response");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hit"}, CacheHit, e.hit);
                chk({e.name, "_err"}, Err, e.err);
                if (e.chk_data) chk({e.name, "_data"}, DataOut, e.data);
            end
        end
    end

    always @(negedge clk)
        if (!rst && Stall)
            assert (Rd || Wr) else $error("Rd/Wr dropped while Stall high");

    // Present a request at a negedge and wait for its Done (latency counted
    // in cycles from presentation); returns in the Done cycle so the next
    // call issues back-to-back.
    task automatic req(input string name, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d, input int lat,
                       input logic [15:0] exp_d, input logic chk_d,
                       input logic hit, input logic err);
        exp_t e;
        int   cyc;
        bit   got;
        e.name = name; e.data = exp_d; e.chk_data = chk_d; e.hit = hit; e.err = err;
        sb.push_back(e);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            got = Done;
        end
        chk({name, "_lat"}, cyc, lat);
    endtask

    task automatic rd(input string name, input logic [15:0] a, input int lat,
                      input logic [15:0] exp_d, input logic chk_d, input logic hit);
        req(name, 1'b1, 1'b0, a, 16'h0, lat, exp_d, chk_d, hit, 1'b0);
    endtask

    task automatic wr(input string name, input logic [15:0] a, input logic [15:0] d,
                      input int lat, input logic hit);
        req(name, 1'b0, 1'b1, a, d, lat, 16'h0, 1'b0, hit, 1'b0);
    endtask

    task automatic idle();
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_done", Done, 1'b0);
        chk("rst_stall", Stall, 1'b0);
        chk("rst_hit", CacheHit, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_dout", DataOut, 16'h0);
        rst = 1'b0;
        @(negedge clk);

        // Prelude: give backing lines 0x0010 and 0x0110 known contents by
        // filling the cache and forcing write-backs, then reset to empty it.
        wr("p_w010", 16'h0010, 16'h1000, 8, 1'b0);
        wr("p_w012", 16'h0012, 16'h1002, 1, 1'b1);
        wr("p_w014", 16'h0014, 16'h1004, 1, 1'b1);
        wr("p_w016", 16'h0016, 16'h1006, 1, 1'b1);
        wr("p_w110", 16'h0110, 16'h2000, 12, 1'b0);
        wr("p_w112", 16'h0112, 16'h2002, 1, 1'b1);
        wr("p_w114", 16'h0114, 16'h2004, 1, 1'b1);
        wr("p_w116", 16'h0116, 16'h2006, 1, 1'b1);
        rd("p_r010", 16'h0010, 12, 16'h1000, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: cold miss then hit
        rd("t1_miss", 16'h0010, 8, 16'h1000, 1'b1, 1'b0);
        rd("t1_hit",  16'h0010, 1, 16'h1000, 1'b1, 1'b1);
        // 2: write hit, read back
        wr("t2_wr",   16'h0010, 16'hBEEF, 1, 1'b1);
        rd("t2_rd",   16'h0010, 1, 16'hBEEF, 1'b1, 1'b1);
        // 3: conflict evicts the dirty line; the write hit re-dirties the
        //    tag-1 line so the return trip also writes back
        rd("t3_conf", 16'h0110, 12, 16'h2000, 1'b1, 1'b0);
        wr("t3_dirt", 16'h0112, 16'h2222, 1, 1'b1);
        rd("t3_back", 16'h0010, 12, 16'hBEEF, 1'b1, 1'b0);
        // 4: illegal requests change nothing
        req("t4_rdwr", 1'b1, 1'b1, 16'h0020, 16'h5555, 1, 16'h0, 1'b0, 1'b0, 1'b1);
        req("t4_odd",  1'b1, 1'b0, 16'h0021, 16'h0, 1, 16'h0, 1'b0, 1'b0, 1'b1);
        rd("t4_keep", 16'h0010, 1, 16'hBEEF, 1'b1, 1'b1);
        rd("t4_noal", 16'h0020, 8, 16'h0, 1'b0, 1'b0);
        // 5: back-to-back hits
        rd("t5_h0", 16'h0010, 1, 16'hBEEF, 1'b1, 1'b1);
        rd("t5_h1", 16'h0012, 1, 16'h1002, 1'b1, 1'b1);
        rd("t5_h2", 16'h0014, 1, 16'h1004, 1'b1, 1'b1);
        rd("t5_h3", 16'h0016, 1, 16'h1006, 1'b1, 1'b1);
        idle();

        // 6: reset in FILL cycle 3 of a clean miss
        Rd = 1'b1; Addr = 16'h0110;
        repeat (3) @(negedge clk);
        chk("t6_stall_fill", Stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_done", Done, 1'b0);
        chk("t6_rst_stall", Stall, 1'b0);
        chk("t6_rst_hit", CacheHit, 1'b0);
        chk("t6_rst_err", Err, 1'b0);
        chk("t6_rst_dout", DataOut, 16'h0);
        Rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd("t6_r110", 16'h0110, 8, 16'h2000, 1'b1, 1'b0);
        rd("t6_r010", 16'h0010, 8, 16'hBEEF, 1'b1, 1'b0);
        idle();
        idle();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
